adc_avg_decim: RTL
==================

# adc_avg_decim

Boxcar averaging decimator that sits directly downstream of the LTC2312 SPI ADC front-end. It consumes the ADC's one-cycle `o_tdata`/`o_tvalid` sample stream and sums 2^LOG2_N consecutive samples. Each full window produces one rounded average on a valid/ready output stream for the DSP or host-register stage.

## Interface
- `WIDTH`, 14: sample and result width in bits; must match the ADC front-end (12 or 14).
- `LOG2_N`, 4: log2 of the window length; legal range 0..8.
- `clk`  in  1: single clock, shared with the ADC front-end.
- `rst_n`  in  1: asynchronous, active-low reset.
- `clear`  in  1: synchronous clear; same effect as reset.
- `enable`  in  1: accumulation enable.
- `i_tdata`  in  WIDTH: unsigned ADC sample.
- `i_tvalid`  in  1: sample strobe. There is no ready signal; the block always accepts.
- `o_tdata`  out  WIDTH: averaged result.
- `o_tvalid`  out  1: result valid.
- `o_tready`  in  1: downstream ready.
- `o_overrun`  out  1: sticky flag; a result was dropped.

## Operation
- States:
  - IDLE: `enable` low.
  - ACC: `enable` high.
- Transitions:
  - IDLE->ACC when `enable` goes high.
  - ACC->IDLE when `enable` goes low. `acc` and `cnt` are zeroed and the partial window is discarded.
- Registers:
  - `acc` is WIDTH+LOG2_N bits, unsigned.
  - `cnt` is a LOG2_N-bit window counter (width 1 when LOG2_N=0).
- In ACC, each cycle with `i_tvalid` high: `acc <= acc + i_tdata` and `cnt <= cnt + 1`.
- On the accepted sample where `cnt == 2^LOG2_N - 1`:
  - `sum = acc + i_tdata`.
  - `result = (sum + 2^(LOG2_N-1)) >> LOG2_N`, evaluated in WIDTH+LOG2_N+1 bits; the rounding term is 0 when LOG2_N=0. This is round-half-up.
  - `acc` and `cnt` return to 0.
- The result never exceeds 2^WIDTH-1, so no saturation logic is required.
- Output register:
  - If `o_tvalid` is low, or `o_tvalid & o_tready` in the same cycle, the result loads and `o_tvalid` goes to 1.
  - Otherwise the new result is dropped, `o_tdata` holds its value, and `o_overrun` is set.
- A handshake with no new result clears `o_tvalid`. `o_tdata` holds its value.
- `o_overrun` clears only on reset or `clear`.
- `clear` or reset zeroes `acc`, `cnt`, `o_tdata`, `o_tvalid` and `o_overrun`, and the block enters IDLE. `clear` has priority over a simultaneous `i_tvalid` or handshake.
- `i_tvalid` is ignored while `enable` is low.

## Timing
- Reset values: `o_tdata`=0, `o_tvalid`=0, `o_overrun`=0 (and `o_min`/`o_max`=0 when compiled in).
- Latency: the result is visible on `o_tdata`/`o_tvalid` one clock after the cycle in which the last window sample had `i_tvalid` high.
- Throughput: at most one result per 2^LOG2_N input strobes. Back-to-back `i_tvalid` is supported.
- LOG2_N=0: one-cycle registered pass-through. Overrun rules still apply.
- `o_tvalid` stays high until the handshake and does not depend on `o_tready` combinationally. No combinational input-to-output paths exist.
- `rst_n` asserts asynchronously and must be deasserted synchronously to `clk` by the system.

## Configuration
- Macro: `ADC_AVG_MINMAX_EN`.
- Defined:
  - Adds output ports `o_min` and `o_max`, each WIDTH bits, holding the minimum and maximum raw sample of the window.
  - They update in the same cycle as, and under the same load/drop rule as, `o_tdata`.
  - Window trackers reset at each window start and on an `enable` drop.
- Undefined: the ports and trackers do not exist. All other behaviour is identical.

## Structure
- Shared package `adc_pkg`:
  - `ADC_WIDTH_DEFAULT` (14).
  - `ADC_LOG2_N_MAX` (8).
  - the state enum `adc_avg_state_t {IDLE, ACC}`.
- One natural sub-module, `adc_win_minmax`, holds the window min/max trackers. It has a start-of-window strobe, a sample strobe and data inputs. It is instantiated only under `ADC_AVG_MINMAX_EN`.

## Test plan
- WIDTH=14, LOG2_N=2, `o_tready`=1, samples 1,2,3,4 -> one result: `o_tdata`=3 ((10+2)>>2), `o_tvalid` high for exactly 1 cycle, 1 clock after the 4th strobe.
- Four samples of 0x3FFF, then four samples of 0 -> results 0x3FFF then 0x0000. No wrap, no overflow.
- `o_tready`=0 across two windows (results 5 then 9) -> `o_tdata` holds 5 and `o_overrun`=1. Handshake with `o_tready`=1 on the cycle the third result 7 arrives -> 7 loads and no additional drop occurs.
- Two samples of 100, then `enable` low for 1 cycle, then samples 8,8,8,8 -> single result 8; the partial window does not contribute.
- `clear` asserted while `o_tvalid`=1 and `o_overrun`=1 -> next cycle all outputs are 0. Async `rst_n` pulse mid-window -> outputs 0 immediately, and the next full window averages correctly.
- With `ADC_AVG_MINMAX_EN`, samples 7,2,9,4 -> `o_tdata`=6 ((22+2)>>2), `o_min`=2, `o_max`=9.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared constants and state type for the ADC averaging decimator.
package adc_pkg;
  localparam int ADC_WIDTH_DEFAULT = 14;
  localparam int ADC_LOG2_N_MAX    = 8;

  typedef enum logic {IDLE, ACC} adc_avg_state_t;
endpackage

// File: rtl/adc_win_minmax.sv
// Running min/max of the raw samples in the current averaging window.
// win_min/win_max already include the sample presented this cycle.
module adc_win_minmax #(
  parameter int WIDTH = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             discard,
  input  logic             start,
  input  logic             sample,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] win_min,
  output logic [WIDTH-1:0] win_max
);
  logic [WIDTH-1:0] min_reg;
  logic [WIDTH-1:0] max_reg;

  always_comb begin
    win_min = min_reg;
    win_max = max_reg;
    if (start) begin
      win_min = data;
      win_max = data;
    end else begin
      if (data < min_reg) win_min = data;
      if (data > max_reg) win_max = data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_reg <= '0;
      max_reg <= '0;
    end else if (clear || discard) begin
      min_reg <= '0;
      max_reg <= '0;
    end else if (sample) begin
      min_reg <= win_min;
      max_reg <= win_max;
    end
  end
endmodule

// File: rtl/adc_avg_decim.sv
// Boxcar averaging decimator: one round-half-up average per 2^LOG2_N samples.
// Optional per-window min/max outputs under ADC_AVG_MINMAX_EN.
module adc_avg_decim
  import adc_pkg::*;
#(
  parameter int WIDTH  = ADC_WIDTH_DEFAULT,
  parameter int LOG2_N = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tvalid,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tvalid,
  input  logic             o_tready,
`ifdef ADC_AVG_MINMAX_EN
  output logic [WIDTH-1:0] o_min,
  output logic [WIDTH-1:0] o_max,
`endif
  output logic             o_overrun
);
  localparam int CW = (LOG2_N == 0) ? 1 : LOG2_N;
  localparam int AW = WIDTH + LOG2_N;
  localparam int SW = AW + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((2 ** LOG2_N) - 1);
  // Half an LSB of the result; integer division makes it 0 for LOG2_N=0.
  localparam logic [SW-1:0] RND = SW'((2 ** LOG2_N) / 2);

  adc_avg_state_t   state_reg;
  logic [AW-1:0]    acc_reg;
  logic [CW-1:0]    cnt_reg;
  logic             accept;
  logic             last;
  logic             load;
  logic             discard;
  logic [SW-1:0]    sum_ext;
  logic [WIDTH-1:0] result;

  assign accept  = enable & i_tvalid;
  assign last    = accept & (cnt_reg == CNT_LAST);
  assign load    = last & (~o_tvalid | o_tready);
  assign discard = (state_reg == ACC) & ~enable;
  assign sum_ext = SW'(acc_reg) + SW'(i_tdata) + RND;
  assign result  = WIDTH'(sum_ext >> LOG2_N);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      cnt_reg   <= '0;
    end else if (clear) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      cnt_reg   <= '0;
    end else if (!enable) begin
      state_reg <= IDLE;
      if (discard) begin
        acc_reg <= '0;
        cnt_reg <= '0;
      end
    end else begin
      state_reg <= ACC;
      if (last) begin
        acc_reg <= '0;
        cnt_reg <= '0;
      end else if (accept) begin
        acc_reg <= acc_reg + AW'(i_tdata);
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  // A completed window either loads the output or is dropped as an overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_tdata   <= '0;
      o_tvalid  <= 1'b0;
      o_overrun <= 1'b0;
    end else if (clear) begin
      o_tdata   <= '0;
      o_tvalid  <= 1'b0;
      o_overrun <= 1'b0;
    end else if (last) begin
      if (load) begin
        o_tdata  <= result;
        o_tvalid <= 1'b1;
      end else begin
        o_overrun <= 1'b1;
      end
    end else if (o_tvalid && o_tready) begin
      o_tvalid <= 1'b0;
    end
  end

`ifdef ADC_AVG_MINMAX_EN
  logic [WIDTH-1:0] win_min;
  logic [WIDTH-1:0] win_max;

  adc_win_minmax #(.WIDTH(WIDTH)) u_minmax (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear),
    .discard (discard),
    .start   (accept && cnt_reg == '0),
    .sample  (accept),
    .data    (i_tdata),
    .win_min (win_min),
    .win_max (win_max)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_min <= '0;
      o_max <= '0;
    end else if (clear) begin
      o_min <= '0;
      o_max <= '0;
    end else if (load) begin
      o_min <= win_min;
      o_max <= win_max;
    end
  end
`endif
endmodule
